// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Load/store wins by default; a streak counter forces a fetch grant after STARVE_LIMIT losses.
//
// state       | meaning
// ST_NORMAL   | load/store has priority over fetch
// ST_FORCE_IF | fetch has waited STARVE_LIMIT ls grants; fetch has priority
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE_IF
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS_LOAD,
        OWN_LS_STORE
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          if_gnt, ls_gnt;
    logic          ls_store;

    // Byte-offset bits carry no meaning for a word-wide RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[1:0], ls_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_NORMAL;
            owner_q  <= OWN_NONE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        owner_d  = OWN_NONE;
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;

        // Grants are held off while reset is asserted so every output reads 0.
        if (rst_ni) begin
            case (state_q)
                ST_NORMAL: begin
                    if (ls_req_i)      ls_gnt = 1'b1;
                    else if (if_req_i) if_gnt = 1'b1;
                end
                ST_FORCE_IF: begin
                    if (if_req_i)      if_gnt = 1'b1;
                    else if (ls_req_i) ls_gnt = 1'b1;
                end
                default: begin
                    if_gnt = 1'b0;
                    ls_gnt = 1'b0;
                end
            endcase
        end

        if (if_gnt || !if_req_i) begin
            streak_d = '0;
        end else if (ls_gnt && (streak_q != LIMIT)) begin
            streak_d = streak_q + 1'b1;
        end

        case (state_q)
            ST_NORMAL:   if (streak_d == LIMIT)       state_d = ST_FORCE_IF;
            ST_FORCE_IF: if (if_gnt || !if_req_i)     state_d = ST_NORMAL;
            default:                                  state_d = ST_NORMAL;
        endcase

        if (if_gnt)      owner_d = OWN_IF;
        else if (ls_gnt) owner_d = ls_we_i ? OWN_LS_STORE : OWN_LS_LOAD;
    end

    assign ls_store    = ls_gnt && ls_we_i;

    assign if_gnt_o    = if_gnt;
    assign ls_gnt_o    = ls_gnt;
    assign mem_en_o    = if_gnt | ls_gnt;
    assign mem_we_o    = ls_store ? ls_be_i : 4'b0000;
    assign mem_wdata_o = ls_store ? ls_wdata_i : 32'h0;
    assign mem_addr_o  = if_gnt ? if_addr_i[ADDR_W-1:2] :
                         ls_gnt ? ls_addr_i[ADDR_W-1:2] : '0;

    assign if_rvalid_o = (owner_q == OWN_IF);
    assign ls_rvalid_o = (owner_q == OWN_LS_LOAD) || (owner_q == OWN_LS_STORE);
    assign if_rdata_o  = (owner_q == OWN_IF)      ? mem_rdata_i : 32'h0;
    assign ls_rdata_o  = (owner_q == OWN_LS_LOAD) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, with a
// priority/starvation reference model and a word-array memory model feeding a response scoreboard.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int LIMIT  = 4;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_gnt_o, if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              ls_req_i = 1'b0;
    logic              ls_we_i = 1'b0;
    logic [3:0]        ls_be_i = '0;
    logic [ADDR_W-1:0] ls_addr_i = '0;
    logic [31:0]       ls_wdata_i = '0;
    logic              ls_gnt_o, ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
        .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];
    bit          ram_loaded;
    bit          ref_loaded;
    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    int          ref_streak;
    bit          ref_force;
    bit          g_if, g_ls;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h00500093;
        if (i == 4) return 32'h12345678;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        if ($urandom_range(0, 15) == 0) a = {10'h3FF, 2'($urandom)};
        else                            a = {6'h00, 4'($urandom), 2'($urandom)};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    // Synchronous RAM: byte writes and registered read in the access cycle.
    always @(posedge clk_i) begin
        if (!ram_loaded) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    // Reference: ls wins unless fetch has already lost LIMIT times in a row while waiting.
    always begin : grant_chk
        bit                e_if, e_ls;
        logic [ADDR_W-3:0] w;
        @(negedge clk_i);
        if (!ref_loaded) begin
            for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1'b1;
        end
        if (rst_ni) begin
            e_if = if_req_i && (ref_force || !ls_req_i);
            e_ls = ls_req_i && !e_if;
            checks++;
            if ({if_gnt_o, ls_gnt_o, mem_en_o} !== {e_if, e_ls, e_if | e_ls}) begin
                errors++;
                $display("FAIL grant at %0t: got if/ls/en=%b%b%b, expected %b%b%b",
                         $time, if_gnt_o, ls_gnt_o, mem_en_o, e_if, e_ls, e_if | e_ls);
            end
            if (e_if) begin
                w = if_addr_i[ADDR_W-1:2];
                if_q.push_back(ref_mem[w]);
                chk("fetch_cmd", {mem_addr_o, mem_we_o}, {w, 4'b0000});
            end
            if (e_ls) begin
                w = ls_addr_i[ADDR_W-1:2];
                if (ls_we_i) begin
                    ls_q.push_back(32'h0);
                    chk("store_cmd", {mem_addr_o, mem_we_o, mem_wdata_o}, {w, ls_be_i, ls_wdata_i});
                    for (int b = 0; b < 4; b++)
                        if (ls_be_i[b]) ref_mem[w][8*b +: 8] = ls_wdata_i[8*b +: 8];
                end else begin
                    ls_q.push_back(ref_mem[w]);
                    chk("load_cmd", {mem_addr_o, mem_we_o}, {w, 4'b0000});
                end
            end
            if (e_if || !if_req_i) begin
                ref_streak = 0;
                ref_force  = 1'b0;
            end else if (e_ls) begin
                ref_streak++;
                if (ref_streak >= LIMIT) ref_force = 1'b1;
            end
            g_if = if_gnt_o;
            g_ls = ls_gnt_o;
        end else begin
            ref_streak = 0;
            ref_force  = 1'b0;
            g_if       = 1'b0;
            g_ls       = 1'b0;
        end
    end

    // Each grant owes exactly one response in the following cycle.
    always begin : resp_mon
        logic [31:0] exp;
        @(posedge clk_i);
        #2;
        if (rst_ni) begin
            checks++;
            if (if_q.size() > 0) begin
                exp = if_q.pop_front();
                if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp) begin
                    errors++;
                    $display("FAIL if_resp at %0t: got valid=%b data=%h, expected valid=1 data=%h",
                             $time, if_rvalid_o, if_rdata_o, exp);
                end
            end else if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0) begin
                errors++;
                $display("FAIL if_idle at %0t: got valid=%b data=%h, expected 0/0",
                         $time, if_rvalid_o, if_rdata_o);
            end
            checks++;
            if (ls_q.size() > 0) begin
                exp = ls_q.pop_front();
                if (ls_rvalid_o !== 1'b1 || ls_rdata_o !== exp) begin
                    errors++;
                    $display("FAIL ls_resp at %0t: got valid=%b data=%h, expected valid=1 data=%h",
                             $time, ls_rvalid_o, ls_rdata_o, exp);
                end
            end else if (ls_rvalid_o !== 1'b0 || ls_rdata_o !== 32'h0) begin
                errors++;
                $display("FAIL ls_idle at %0t: got valid=%b data=%h, expected 0/0",
                         $time, ls_rvalid_o, ls_rdata_o);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors + 1);
        $fatal(1, "timeout");
    end

    function automatic logic any_out();
        return |{if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
                 mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};
    endfunction

    initial begin : driver
        logic [11:0] pat, pat_exp;
        int          n_ls;
        bit          got;

        repeat (3) @(posedge clk_i);
        #1 chk("reset_outputs", 64'(any_out()), 64'h0);
        rst_ni = 1'b1;
        next();

        // Fetch of word 1 returns the preloaded instruction.
        if_req_i  = 1'b1;
        if_addr_i = 12'h004;
        #1 chk("fetch_gnt", {if_gnt_o, mem_en_o, mem_addr_o}, {1'b1, 1'b1, 10'h001});
        next();
        if_req_i = 1'b0;
        #1 chk("fetch_rdata", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h00500093});

        // Async reset while the fetch response is on the bus, with both requests raised.
        #1 rst_ni = 1'b0;
        if_q.delete();
        ls_q.delete();
        if_req_i = 1'b1;
        ls_req_i = 1'b1;
        #1 chk("reset_async_outputs", 64'(any_out()), 64'h0);
        next();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        next();
        rst_ni = 1'b1;
        next();
        #1 chk("post_reset_rvalid", {if_rvalid_o, ls_rvalid_o}, 2'b00);

        // Partial store then load of the same word.
        next();
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_be_i    = 4'b0011;
        ls_addr_i  = 12'h010;
        ls_wdata_i = 32'hDEADBEEF;
        #1 chk("store_we", {ls_gnt_o, mem_we_o, mem_addr_o}, {1'b1, 4'b0011, 10'h004});
        next();
        ls_we_i = 1'b0;
        #1 chk("store_ack", {ls_rvalid_o, ls_rdata_o}, {1'b1, 32'h0});
        next();
        ls_req_i = 1'b0;
        #1 chk("load_after_store", {ls_rvalid_o, ls_rdata_o}, {1'b1, 32'h1234BEEF});

        // Top word of the address space.
        next();
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_be_i    = 4'b1111;
        ls_addr_i  = 12'hFFF;
        ls_wdata_i = 32'hCAFEF00D;
        #1 chk("top_word_addr", 64'(mem_addr_o), 64'h3FF);
        next();
        ls_we_i   = 1'b0;
        ls_addr_i = 12'hFFC;
        next();
        ls_req_i = 1'b0;
        #1 chk("top_word_load", {ls_rvalid_o, ls_rdata_o}, {1'b1, 32'hCAFEF00D});
        next();

        // Sustained contention.
        next();
        if_req_i  = 1'b1;
        if_addr_i = 12'h020;
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 12'h030;
        for (int k = 0; k < 12; k++) begin
            next();
            pat[k]     = g_ls;
            pat_exp[k] = (k % 5) != 4;
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        chk("contention_pattern", 64'(pat), 64'(pat_exp));

        // Alternating single requesters: responses interleave with no gap.
        for (int k = 0; k <= 8; k++) begin
            next();
            if_req_i  = (k < 8) && (k % 2 == 0);
            ls_req_i  = (k < 8) && (k % 2 == 1);
            if_addr_i = rand_addr();
            ls_addr_i = rand_addr();
            ls_we_i   = 1'b0;
            if (k > 0)
                #1 chk("b2b_valid", {if_rvalid_o, ls_rvalid_o}, ((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Fetch withdrawn after one cycle of losing to ls.
        next();
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_addr_i = 12'h050;
        next();
        if_req_i  = 1'b1;
        if_addr_i = 12'h040;
        next();
        if_req_i = 1'b0;
        chk("withdrawn_no_gnt", 64'(g_if), 64'h0);
        next();
        if_req_i = 1'b1;
        #1 chk("withdrawn_no_rvalid", 64'(if_rvalid_o), 64'h0);
        n_ls = 0;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            next();
            if (g_if)      got = 1'b1;
            else if (g_ls) n_ls++;
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        chk("withdraw_then_starve", {got, 8'(n_ls)}, {1'b1, 8'd4});

        // Randomized traffic; requests hold until granted, occasionally withdrawn.
        for (int n = 0; n < 3000; n++) begin
            next();
            if (if_req_i && !g_if) begin
                if ($urandom_range(0, 7) == 0) if_req_i = 1'b0;
            end else begin
                if_req_i  = ($urandom_range(0, 3) != 0);
                if_addr_i = rand_addr();
            end
            if (ls_req_i && !g_ls) begin
                if ($urandom_range(0, 7) == 0) ls_req_i = 1'b0;
            end else begin
                ls_req_i   = ($urandom_range(0, 3) != 0);
                ls_we_i    = ($urandom_range(0, 2) == 0);
                ls_be_i    = 4'($urandom);
                ls_addr_i  = rand_addr();
                ls_wdata_i = $urandom;
            end
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (3) next();
        #3 chk("queues_drained", 64'(if_q.size() + ls_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
